// File: rtl/nn_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_sequencer_if : board/memory/network handshake bundle for nn_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface nn_sequencer_if #(
  parameter int outWidth   = 4,
  parameter int NUM_FRAMES = 1
);
  localparam int FIW = $clog2(NUM_FRAMES + 1);

  logic                enable;
  logic                mem_valid;
  logic                mem_last;
  logic                mem_ren;
  logic                net_out_valid;
  logic [outWidth-1:0] net_out_data;
  logic [outWidth-1:0] result;
  logic                result_valid;
  logic                done;
  logic                busy;
  logic [FIW-1:0]      frame_idx;
  logic                exhausted;
  logic                error;
  logic [1:0]          err_code;

  modport master (
    output enable, mem_valid, mem_last, net_out_valid, net_out_data,
    input  mem_ren, result, result_valid, done, busy, frame_idx,
           exhausted, error, err_code
  );

  modport slave (
    input  enable, mem_valid, mem_last, net_out_valid, net_out_data,
    output mem_ren, result, result_valid, done, busy, frame_idx,
           exhausted, error, err_code
  );
endinterface
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_sequencer : frame controller between nn_memory and net (start, length
// check, result hold, fault flag). Optional watchdog: NN_SEQ_WATCHDOG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module nn_sequencer #(
  parameter int outWidth   = 4,
  parameter int FRAME_LEN  = 784,
  parameter int NUM_FRAMES = 1,
  parameter int TIMEOUT    = 4096
) (
  input  wire           clk,
  input  wire           rst,
  nn_sequencer_if.slave bus
);
  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam int FIW = $clog2(NUM_FRAMES + 1);

  localparam logic [1:0] c_ERR_LEN = 2'b01;
  localparam logic [1:0] c_ERR_RES = 2'b10;
  localparam logic [1:0] c_ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_enable_q;
  logic [BCW-1:0]      r_beat_cnt;
  logic                r_mem_ren;
  logic [outWidth-1:0] r_result;
  logic                r_result_valid;
  logic                r_done;
  logic                r_busy;
  logic [FIW-1:0]      r_frame_idx;
  logic                r_exhausted;
  logic                r_error;
  logic [1:0]          r_err_code;

  logic                w_start;
  logic [BCW:0]        w_beats_incl;
  logic                w_wd_expire;
  logic                w_len_fault;
  logic                w_res_fault;
  logic                w_tmo_fault;
  logic                w_fault;
  logic [1:0]          w_fault_code;

`ifdef NN_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd;
  // Fires on the edge that would take the count to TIMEOUT.
  assign w_wd_expire = (r_wd == WDW'(TIMEOUT - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  assign w_start      = bus.enable & ~r_enable_q & ~r_exhausted & ~r_error;
  assign w_beats_incl = {1'b0, r_beat_cnt} + (BCW+1)'(bus.mem_valid);

  always_comb begin
    w_len_fault = 1'b0;
    w_res_fault = 1'b0;
    w_tmo_fault = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_res_fault = bus.net_out_valid;
      S_READ: begin
        w_len_fault = (bus.mem_valid && (r_beat_cnt == BCW'(FRAME_LEN))) ||
                      (bus.mem_last && (w_beats_incl != (BCW+1)'(FRAME_LEN)));
        w_res_fault = bus.net_out_valid;
        w_tmo_fault = w_wd_expire && !bus.mem_valid;
      end
      S_WAIT: begin
        w_len_fault = bus.mem_valid;
        w_tmo_fault = w_wd_expire;
      end
      default: ;
    endcase
    w_fault      = w_len_fault | w_res_fault | w_tmo_fault;
    w_fault_code = w_len_fault ? c_ERR_LEN : (w_res_fault ? c_ERR_RES : c_ERR_TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_enable_q     <= 1'b0;
      r_beat_cnt     <= '0;
      r_mem_ren      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_idx    <= '0;
      r_exhausted    <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= 2'b00;
`ifdef NN_SEQ_WATCHDOG_EN
      r_wd           <= '0;
`endif
    end else begin
      r_enable_q <= bus.enable;
      r_done     <= 1'b0;
      if (w_fault) begin
        r_state    <= S_ERROR;
        r_error    <= 1'b1;
        r_err_code <= w_fault_code;
        r_mem_ren  <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state        <= S_READ;
              r_mem_ren      <= 1'b1;
              r_busy         <= 1'b1;
              r_beat_cnt     <= '0;
              r_result_valid <= 1'b0;
`ifdef NN_SEQ_WATCHDOG_EN
              r_wd           <= '0;
`endif
            end
          end
          S_READ: begin
            if (bus.mem_valid) r_beat_cnt <= r_beat_cnt + BCW'(1);
`ifdef NN_SEQ_WATCHDOG_EN
            r_wd <= (bus.mem_valid || bus.mem_last) ? '0 : r_wd + WDW'(1);
`endif
            if (bus.mem_last) begin
              r_state   <= S_WAIT;
              r_mem_ren <= 1'b0;
            end
          end
          S_WAIT: begin
`ifdef NN_SEQ_WATCHDOG_EN
            r_wd <= r_wd + WDW'(1);
`endif
            if (bus.net_out_valid) begin
              r_state        <= S_DONE;
              r_result       <= bus.net_out_data;
              r_result_valid <= 1'b1;
              r_frame_idx    <= r_frame_idx + FIW'(1);
              r_exhausted    <= ((r_frame_idx + FIW'(1)) == FIW'(NUM_FRAMES));
              r_done         <= 1'b1;
              r_busy         <= 1'b0;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_ERROR;
        endcase
      end
    end
  end

  assign bus.mem_ren      = r_mem_ren;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.done         = r_done;
  assign bus.busy         = r_busy;
  assign bus.frame_idx    = r_frame_idx;
  assign bus.exhausted    = r_exhausted;
  assign bus.error        = r_error;
  assign bus.err_code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nn_sequencer : directed self-checking bench for nn_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_nn_sequencer;
  localparam int c_OW  = 4;
  localparam int c_FL  = 4;
  localparam int c_NF  = 2;
  localparam int c_TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nn_sequencer_if #(.outWidth(c_OW), .NUM_FRAMES(c_NF)) ifc ();

  nn_sequencer #(
    .outWidth(c_OW), .FRAME_LEN(c_FL), .NUM_FRAMES(c_NF), .TIMEOUT(c_TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    ifc.enable = 1'b1;
    tick();
    ifc.enable = 1'b0;
  endtask

  task automatic beats(input int n, input int last_at);
    for (int i = 1; i <= n; i++) begin
      ifc.mem_valid = 1'b1;
      ifc.mem_last  = (i == last_at);
      tick();
    end
    ifc.mem_valid = 1'b0;
    ifc.mem_last  = 1'b0;
  endtask

  task automatic classify(input logic [3:0] d);
    ifc.net_out_valid = 1'b1;
    ifc.net_out_data  = d;
    tick();
    ifc.net_out_valid = 1'b0;
    ifc.net_out_data  = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_ren"},      ifc.mem_ren,      0);
    chk({tag, ".busy"},         ifc.busy,         0);
    chk({tag, ".done"},         ifc.done,         0);
    chk({tag, ".result"},       ifc.result,       0);
    chk({tag, ".result_valid"}, ifc.result_valid, 0);
    chk({tag, ".frame_idx"},    ifc.frame_idx,    0);
    chk({tag, ".exhausted"},    ifc.exhausted,    0);
    chk({tag, ".error"},        ifc.error,        0);
    chk({tag, ".err_code"},     ifc.err_code,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    ifc.enable        = 1'b0;
    ifc.mem_valid     = 1'b0;
    ifc.mem_last      = 1'b0;
    ifc.net_out_valid = 1'b0;
    ifc.net_out_data  = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;

    // Nominal frame 1
    start();
    chk("nom.ren_on",  ifc.mem_ren, 1);
    chk("nom.busy_on", ifc.busy,    1);
    beats(3, 0);
    chk("nom.ren_mid", ifc.mem_ren, 1);
    beats(1, 1);
    chk("nom.ren_off",   ifc.mem_ren, 0);
    chk("nom.busy_wait", ifc.busy,    1);
    tick(); tick();
    classify(4'd7);
    chk("nom.result", ifc.result,       7);
    chk("nom.rv",     ifc.result_valid, 1);
    chk("nom.done",   ifc.done,         1);
    chk("nom.fidx",   ifc.frame_idx,    1);
    chk("nom.busy",   ifc.busy,         0);
    chk("nom.exh",    ifc.exhausted,    0);
    tick();
    chk("nom.done_off", ifc.done, 0);

    // Frame 2 at minimum restart distance
    start();
    chk("f2.ren_on", ifc.mem_ren,      1);
    chk("f2.rv_clr", ifc.result_valid, 0);
    beats(4, 4);
    classify(4'd9);
    chk("f2.result", ifc.result,    9);
    chk("f2.fidx",   ifc.frame_idx, 2);
    chk("f2.exh",    ifc.exhausted, 1);
    tick();

    // Exhaustion: pulse and held level are both ignored
    start();
    chk("exh.ren", ifc.mem_ren, 0);
    chk("exh.busy", ifc.busy,   0);
    tick();
    ifc.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("exh.hold_ren", ifc.mem_ren, 0);
    end
    ifc.enable = 1'b0;
    chk("exh.result_hold", ifc.result, 9);

    // Spurious result during READ
    do_reset();
    chk("sp.fidx_rst", ifc.frame_idx, 0);
    start();
    beats(4, 4);
    classify(4'd5);
    tick();
    start();
    beats(2, 0);
    classify(4'd12);
    chk("sp.err",    ifc.error,        1);
    chk("sp.code",   ifc.err_code,     2);
    chk("sp.result", ifc.result,       5);
    chk("sp.rv",     ifc.result_valid, 0);
    chk("sp.ren",    ifc.mem_ren,      0);
    chk("sp.busy",   ifc.busy,         0);
    start();
    chk("sp.sticky_ren",  ifc.mem_ren,  0);
    chk("sp.sticky_code", ifc.err_code, 2);

    // Length fault beats result fault in the same cycle
    do_reset();
    start();
    beats(1, 0);
    ifc.mem_valid     = 1'b1;
    ifc.mem_last      = 1'b1;
    ifc.net_out_valid = 1'b1;
    tick();
    ifc.mem_valid     = 1'b0;
    ifc.mem_last      = 1'b0;
    ifc.net_out_valid = 1'b0;
    chk("prio.code", ifc.err_code, 1);

    // Short frame
    do_reset();
    start();
    beats(3, 3);
    chk("short.err",  ifc.error,    1);
    chk("short.code", ifc.err_code, 1);
    chk("short.ren",  ifc.mem_ren,  0);
    tick(); tick(); tick();
    chk("short.sticky_err",  ifc.error,    1);
    chk("short.sticky_code", ifc.err_code, 1);
    do_reset();
    chk_reset("short.rst");

    // Extra beat after FRAME_LEN without mem_last
    start();
    beats(5, 0);
    chk("long.code", ifc.err_code, 1);
    do_reset();

    // Reset mid-READ
    start();
    beats(2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    start();
    chk("midrst.ren_on", ifc.mem_ren, 1);
    beats(4, 4);
    chk("midrst.ren_off", ifc.mem_ren, 0);
    classify(4'd3);
    chk("midrst.result", ifc.result,    3);
    chk("midrst.fidx",   ifc.frame_idx, 1);
    chk("midrst.done",   ifc.done,      1);
    chk("midrst.err",    ifc.error,     0);

    // Watchdog in WAIT
    do_reset();
    start();
    beats(4, 4);
`ifdef NN_SEQ_WATCHDOG_EN
    for (int i = 1; i <= c_TMO; i++) begin
      tick();
      if (i == c_TMO - 1) chk("wd.pre_err", ifc.error, 0);
    end
    chk("wd.err",  ifc.error,    1);
    chk("wd.code", ifc.err_code, 3);
    chk("wd.busy", ifc.busy,     0);
`else
    for (int i = 0; i < c_TMO + 8; i++) tick();
    chk("nowd.busy", ifc.busy,     1);
    chk("nowd.err",  ifc.error,    0);
    chk("nowd.code", ifc.err_code, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nn_sequencer.md
# nn_sequencer

Frame-level controller for the handwritten-digit network. It sits between the board inputs, `nn_memory` and `net`, and replaces the ad-hoc read-enable/last-done logic in the top level. It starts one image per `enable` rising edge, checks the memory stream length, and waits for the network's classification. It then holds the result for the LEDs and flags protocol faults. It counts frames and refuses further starts once `NUM_FRAMES` images have been classified.

## Interface
- `outWidth`, 4: width of the class index from `net`.
- `FRAME_LEN`, 784: memory beats (`mem_valid` cycles) per image.
- `NUM_FRAMES`, 1: images stored in memory; starts are ignored after this many.
- `TIMEOUT`, 4096: watchdog limit in idle-stream cycles (used only with `NN_SEQ_WATCHDOG_EN`).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: start request, level input; rising edge is used.
- `mem_valid`  in  1: memory beat valid.
- `mem_last`  in  1: memory end-of-frame marker.
- `mem_ren`  out  1: memory read enable (registered).
- `net_out_valid`  in  1: classification valid from `net`.
- `net_out_data`  in  outWidth: class index from `net`.
- `result`  out  outWidth: held class index, drives the LEDs.
- `result_valid`  out  1: high while `result` holds a classification from the current run.
- `done`  out  1: one-cycle pulse per classified frame.
- `busy`  out  1: high in READ or WAIT.
- `frame_idx`  out  clog2(NUM_FRAMES+1): number of frames completed.
- `exhausted`  out  1: `frame_idx == NUM_FRAMES`.
- `error`  out  1: sticky fault flag.
- `err_code`  out  2: 00 none, 01 length, 10 spurious result, 11 timeout.

## Operation
- Reset values:
  - State is IDLE.
  - `mem_ren`, `result_valid`, `done`, `busy`, `error` are all 0.
  - `result`, `frame_idx`, `err_code` are 0.
  - `enable_q` is 0, so an `enable` held high through reset starts a frame on the first cycle after reset.
- The start condition is `enable & ~enable_q & ~exhausted & ~error`. `enable_q` is the registered `enable`.
- IDLE:
  - On start, go to READ.
  - Clear the beat counter and the watchdog counter.
  - Clear `result_valid`.
- READ:
  - `mem_ren` = 1.
  - The beat counter, width clog2(FRAME_LEN+1), increments on each `mem_valid`.
  - When `mem_last` is sampled high, go to WAIT and drop `mem_ren`. This requires beats counted including the current one to equal FRAME_LEN; otherwise go to ERROR with code 01.
  - A `mem_valid` arriving when the counter already equals FRAME_LEN is also a code 01 error.
  - `net_out_valid` in READ is a code 10 error.
- WAIT:
  - `mem_ren` = 0.
  - On `net_out_valid`, latch `net_out_data` into `result`, set `result_valid`, increment `frame_idx`, and go to DONE.
  - `mem_valid` in WAIT is a code 01 error.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE. `result` and `result_valid` hold.
- `net_out_valid` in IDLE or DONE is a code 10 error.
- ERROR:
  - The state is absorbing until `rst`.
  - `mem_ren` = 0 and `busy` = 0.
  - `error` = 1, and `err_code` keeps the first fault.
  - `result` and `result_valid` retain their pre-fault values.
- Simultaneous events: if a length fault and a result fault occur in the same cycle, code 01 wins.
- Reset mid-frame returns to IDLE in one cycle. The memory read pointer is not reset by this block.

## Timing
- `enable` rises and is sampled at edge N: `mem_ren` and `busy` are high after N.
- `mem_last` is sampled at edge M: `mem_ren` is low after M, the same cycle as the state change.
- `net_out_valid` is sampled at edge K:
  - `result`, `result_valid` and `frame_idx` update after K.
  - `done` is high from K to K+1.
  - The block is back in IDLE after K+1.
- Minimum restart: a new `enable` edge sampled at K+2.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `NN_SEQ_WATCHDOG_EN` defined:
  - A counter of width clog2(TIMEOUT+1) runs in READ and WAIT.
  - It clears on `mem_valid` in READ and on state entry.
  - When it reaches TIMEOUT, the block goes to ERROR with code 11.
- Undefined: there is no counter, and code 11 is never produced. READ and WAIT may wait indefinitely.

## Test plan
- **Nominal frame:**
  - Stimulus: FRAME_LEN=4, NUM_FRAMES=2; `enable` pulse; 4 `mem_valid` beats, `mem_last` on the 4th; `net_out_valid` with data 7 three cycles later.
  - Required: `mem_ren` high 1 cycle after the edge and low after `mem_last`; `result`=7, `result_valid`=1, one-cycle `done`, `frame_idx`=1.
- **Exhaustion:**
  - Stimulus: after two frames, pulse `enable` again; also hold `enable` high for 10 cycles.
  - Required: `exhausted`=1, `mem_ren` stays 0, no restart from the held level.
- **Short frame:**
  - Stimulus: `mem_last` on the 3rd beat with FRAME_LEN=4.
  - Required: `error`=1, `err_code`=01, `mem_ren`=0 the next cycle; the state stays sticky until `rst`, after which everything reads 0.
- **Spurious result:**
  - Stimulus: `net_out_valid` during READ.
  - Required: `err_code`=10; `result` unchanged from the previous frame.
- **Watchdog (with `NN_SEQ_WATCHDOG_EN`):**
  - Stimulus: TIMEOUT=16; no `net_out_valid` in WAIT.
  - Required: `err_code`=11 exactly 16 cycles after entering WAIT.
  - Without the macro, the same stimulus stays in WAIT with `busy`=1 indefinitely.
- **Reset mid-READ:**
  - Stimulus: assert `rst` for one cycle after 2 beats.
  - Required: all outputs at reset values the next cycle; a new `enable` edge starts a fresh frame.
